// File: rtl/vdp99_cpu_port_if.sv
// VRAM request bus between the vdp99 CPU port (master) and the VRAM arbiter (slave).
// One outstanding single-byte access. vram_req rises with the request and stays high until vram_ack.
// vram_we, vram_addr and vram_wdata are stable while vram_req is high.
// vram_ack is a one-cycle pulse; vram_rdata is valid in the same cycle.
interface vdp99_cpu_port_if #(
    parameter int ADDR_W = 14
);
    logic              vram_req;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_ack;
    logic [7:0]        vram_rdata;

    modport master (
        output vram_req, vram_we, vram_addr, vram_wdata,
        input  vram_ack, vram_rdata
    );

    modport slave (
        input  vram_req, vram_we, vram_addr, vram_wdata,
        output vram_ack, vram_rdata
    );
endinterface

// File: rtl/vdp99_cpu_port.sv
// TMS9918-style CPU port: two-byte control writes, mode registers, an auto-incrementing
// VRAM address with read-ahead buffer, and the status register. Issues one VRAM access at a time.
module vdp99_cpu_port #(
    parameter int ADDR_W = 14
) (
    input  logic        pxclk,
    input  logic        reset,
    input  logic        wr_tick,
    input  logic        rd_tick,
    input  logic        mode,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        irq,
    output logic [63:0] regs,
    input  logic        frame_tick,
    input  logic        coll_set,
    input  logic        fifth_set,
    input  logic [4:0]  fifth_num,
    output logic        busy,
    output logic        overrun,
    vdp99_cpu_port_if.master vram
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0][7:0]   r_regs;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_rd_buf;
    logic [7:0]        r_latch;
    logic              r_toggle;
    logic              r_f;
    logic              r_5s;
    logic              r_c;
    logic [4:0]        r_num;
    logic              r_overrun;
    logic              r_vram_we;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [7:0]        r_vram_wdata;

    logic              w_ctrl_wr;
    logic              w_data_wr;
    logic              w_stat_rd;
    logic              w_data_rd;
    logic              w_ctrl_second;
    logic              w_reg_wr;
    logic              w_addr_wr;
    logic              w_setup_rd;
    logic              w_need;
    logic              w_idle;
    logic              w_issue;
    logic              w_drop;
    logic              w_ack;
    logic [13:0]       w_setup_addr;
    logic [ADDR_W-1:0] w_load_addr;
    logic [ADDR_W-1:0] w_addr_src;

    // A write strobe masks a coincident read strobe.
    assign w_ctrl_wr     = wr_tick & mode;
    assign w_data_wr     = wr_tick & ~mode;
    assign w_stat_rd     = rd_tick & ~wr_tick & mode;
    assign w_data_rd     = rd_tick & ~wr_tick & ~mode;
    assign w_ctrl_second = w_ctrl_wr & r_toggle;
    assign w_reg_wr      = w_ctrl_second & din[7];
    assign w_addr_wr     = w_ctrl_second & ~din[7];
    assign w_setup_rd    = w_addr_wr & ~din[6];
    assign w_need        = w_data_wr | w_data_rd | w_setup_rd;
    assign w_idle        = (r_state == IDLE);
    assign w_issue       = w_need & w_idle;
    assign w_drop        = w_need & ~w_idle;
    assign w_ack         = vram.vram_ack & ~w_idle;
    assign w_setup_addr  = {din[5:0], r_latch};
    assign w_load_addr   = ADDR_W'(w_setup_addr);
    // A read setup fetches from the address it is loading, not the old one.
    assign w_addr_src    = w_addr_wr ? w_load_addr : r_addr;

    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_next_state = WAIT;
            WAIT:    if (vram.vram_ack) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            r_regs       <= '0;
            r_addr       <= '0;
            r_rd_buf     <= '0;
            r_latch      <= '0;
            r_toggle     <= 1'b0;
            r_overrun    <= 1'b0;
            r_vram_we    <= 1'b0;
            r_vram_addr  <= '0;
            r_vram_wdata <= '0;
        end else begin
            if (w_ctrl_wr)                  r_toggle <= ~r_toggle;
            else if (wr_tick || rd_tick)    r_toggle <= 1'b0;
            if (w_ctrl_wr && !r_toggle)     r_latch <= din;
            if (w_reg_wr)                   r_regs[din[2:0]] <= r_latch;
            if (w_drop)                     r_overrun <= 1'b1;
            if (w_issue) begin
                r_addr       <= w_addr_src + ADDR_W'(1);
                r_vram_we    <= w_data_wr;
                r_vram_addr  <= w_addr_src;
                r_vram_wdata <= din;
                if (w_data_wr) r_rd_buf <= din;
            end else if (w_addr_wr) begin
                r_addr <= w_load_addr;
            end
            if (w_ack && !r_vram_we)        r_rd_buf <= vram.vram_rdata;
        end
    end

    // Status flags: a set event in the same cycle as a status read wins over the clear.
    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            r_f   <= 1'b0;
            r_5s  <= 1'b0;
            r_c   <= 1'b0;
            r_num <= '0;
        end else begin
            r_f  <= frame_tick | (r_f & ~w_stat_rd);
            r_c  <= coll_set | (r_c & ~w_stat_rd);
            r_5s <= fifth_set | (r_5s & ~w_stat_rd);
            if (fifth_set && !r_5s) r_num <= fifth_num;
        end
    end

    assign dout            = mode ? {r_f, r_5s, r_c, r_num} : r_rd_buf;
    assign irq             = r_f & r_regs[1][5];
    assign regs            = r_regs;
    assign busy            = ~w_idle;
    assign overrun         = r_overrun;
    assign vram.vram_req   = ~w_idle;
    assign vram.vram_we    = r_vram_we;
    assign vram.vram_addr  = r_vram_addr;
    assign vram.vram_wdata = r_vram_wdata;

endmodule

// File: tb/tb_vdp99_cpu_port.sv
// Directed testbench for vdp99_cpu_port: control protocol, VRAM request handshake,
// overrun handling, status flags and asynchronous reset during an outstanding request.
module tb_vdp99_cpu_port;

    logic        pxclk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_tick = 1'b0;
    logic        rd_tick = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        irq;
    logic [63:0] regs;
    logic        frame_tick = 1'b0;
    logic        coll_set = 1'b0;
    logic        fifth_set = 1'b0;
    logic [4:0]  fifth_num = 5'd0;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    vdp99_cpu_port_if #(.ADDR_W(14)) vif ();

    vdp99_cpu_port #(.ADDR_W(14)) dut (
        .pxclk      (pxclk),
        .reset      (reset),
        .wr_tick    (wr_tick),
        .rd_tick    (rd_tick),
        .mode       (mode),
        .din        (din),
        .dout       (dout),
        .irq        (irq),
        .regs       (regs),
        .frame_tick (frame_tick),
        .coll_set   (coll_set),
        .fifth_set  (fifth_set),
        .fifth_num  (fifth_num),
        .busy       (busy),
        .overrun    (overrun),
        .vram       (vif)
    );

    always #5 pxclk = ~pxclk;

    // All drivers start and end at 1 time unit after a rising edge.
    task automatic step();
        @(posedge pxclk);
        #1;
    endtask

    task automatic do_wr(input logic m, input logic [7:0] d);
        wr_tick = 1'b1;
        mode    = m;
        din     = d;
        step();
        wr_tick = 1'b0;
    endtask

    task automatic do_rd(input logic m, output logic [7:0] d);
        rd_tick = 1'b1;
        mode    = m;
        #1;
        d = dout;
        step();
        rd_tick = 1'b0;
    endtask

    task automatic do_ack(input int delay, input logic [7:0] rdata);
        repeat (delay) step();
        vif.vram_ack   = 1'b1;
        vif.vram_rdata = rdata;
        step();
        vif.vram_ack   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        reset = 1'b0;
        step();
        mode = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout_data got %h exp 00", dout); end
        mode = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout_stat got %h exp 00", dout); end
        checks++;
        if ({irq, busy, overrun, vif.vram_req} !== 4'b0000)
        begin errors++; $display("FAIL rst_flags got %b exp 0000", {irq, busy, overrun, vif.vram_req}); end
        checks++;
        if (regs !== 64'h0) begin errors++; $display("FAIL rst_regs got %h exp 0", regs); end
        step();
    endtask

    task automatic test_regs();
        logic [7:0] d;
        do_wr(1'b1, 8'h55);
        do_wr(1'b1, 8'h81);
        checks++;
        if (regs !== 64'h0000_0000_0000_5500) begin errors++; $display("FAIL reg1_write got %h exp 5500", regs); end
        checks++;
        if (vif.vram_req !== 1'b0) begin errors++; $display("FAIL reg1_noreq got %b exp 0", vif.vram_req); end
        do_wr(1'b1, 8'h20);
        do_wr(1'b1, 8'h81);
        checks++;
        if (regs[15:8] !== 8'h20) begin errors++; $display("FAIL reg1_rewrite got %h exp 20", regs[15:8]); end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
        do_rd(1'b1, d);
        checks++;
        if (d !== 8'h80) begin errors++; $display("FAIL stat_f got %h exp 80", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
    endtask

    task automatic test_write();
        logic [7:0] d;
        do_wr(1'b1, 8'h34);
        do_wr(1'b1, 8'h52);
        checks++;
        if (vif.vram_req !== 1'b0) begin errors++; $display("FAIL wsetup_noreq got %b exp 0", vif.vram_req); end
        do_wr(1'b0, 8'hAA);
        checks++;
        if ({vif.vram_req, vif.vram_we, vif.vram_addr, vif.vram_wdata} !== {2'b11, 14'h1234, 8'hAA})
        begin errors++; $display("FAIL wr1_req got %b %b %h %h exp 1 1 1234 aa",
            vif.vram_req, vif.vram_we, vif.vram_addr, vif.vram_wdata); end
        repeat (2) step();
        checks++;
        if ({vif.vram_req, busy, vif.vram_addr, vif.vram_wdata} !== {2'b11, 14'h1234, 8'hAA})
        begin errors++; $display("FAIL wr1_hold got %b %b %h %h exp 1 1 1234 aa",
            vif.vram_req, busy, vif.vram_addr, vif.vram_wdata); end
        do_ack(0, 8'h00);
        checks++;
        if ({vif.vram_req, busy} !== 2'b00) begin errors++; $display("FAIL wr1_done got %b exp 00", {vif.vram_req, busy}); end
        do_wr(1'b0, 8'hBB);
        checks++;
        if ({vif.vram_req, vif.vram_we, vif.vram_addr, vif.vram_wdata} !== {2'b11, 14'h1235, 8'hBB})
        begin errors++; $display("FAIL wr2_req got %b %b %h %h exp 1 1 1235 bb",
            vif.vram_req, vif.vram_we, vif.vram_addr, vif.vram_wdata); end
        do_ack(2, 8'h00);
        do_rd(1'b0, d);
        checks++;
        if (d !== 8'hBB) begin errors++; $display("FAIL wr_rdbuf got %h exp bb", d); end
        checks++;
        if ({vif.vram_req, vif.vram_we, vif.vram_addr} !== {2'b10, 14'h1236})
        begin errors++; $display("FAIL rd_after_wr got %b %b %h exp 1 0 1236",
            vif.vram_req, vif.vram_we, vif.vram_addr); end
        do_ack(1, 8'h11);
    endtask

    task automatic test_read_wrap();
        logic [7:0] d;
        do_wr(1'b1, 8'hFF);
        do_wr(1'b1, 8'h3F);
        checks++;
        if ({vif.vram_req, vif.vram_we, vif.vram_addr} !== {2'b10, 14'h3FFF})
        begin errors++; $display("FAIL rsetup_req got %b %b %h exp 1 0 3fff",
            vif.vram_req, vif.vram_we, vif.vram_addr); end
        do_ack(1, 8'h5A);
        do_rd(1'b0, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL rsetup_data got %h exp 5a", d); end
        checks++;
        if ({vif.vram_req, vif.vram_we, vif.vram_addr} !== {2'b10, 14'h0000})
        begin errors++; $display("FAIL addr_wrap got %b %b %h exp 1 0 0000",
            vif.vram_req, vif.vram_we, vif.vram_addr); end
        do_ack(1, 8'h66);
        do_rd(1'b0, d);
        checks++;
        if (d !== 8'h66) begin errors++; $display("FAIL rd_next_data got %h exp 66", d); end
        do_ack(1, 8'h00);
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        do_wr(1'b1, 8'h00);
        do_wr(1'b1, 8'h50);
        do_wr(1'b0, 8'h01);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre got %b exp 0", overrun); end
        do_wr(1'b0, 8'h02);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
        checks++;
        if ({vif.vram_req, vif.vram_addr, vif.vram_wdata} !== {1'b1, 14'h1000, 8'h01})
        begin errors++; $display("FAIL ovr_hold got %b %h %h exp 1 1000 01",
            vif.vram_req, vif.vram_addr, vif.vram_wdata); end
        do_ack(0, 8'h00);
        do_wr(1'b0, 8'h03);
        checks++;
        if ({vif.vram_req, vif.vram_addr, vif.vram_wdata} !== {1'b1, 14'h1001, 8'h03})
        begin errors++; $display("FAIL ovr_addr_once got %b %h %h exp 1 1001 03",
            vif.vram_req, vif.vram_addr, vif.vram_wdata); end
        do_rd(1'b0, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL busy_rd_data got %h exp 03", d); end
        do_wr(1'b1, 8'h00);
        do_wr(1'b1, 8'h60);
        checks++;
        if ({vif.vram_req, vif.vram_we, vif.vram_addr} !== {2'b11, 14'h1001})
        begin errors++; $display("FAIL busy_addr_wr got %b %b %h exp 1 1 1001",
            vif.vram_req, vif.vram_we, vif.vram_addr); end
        do_ack(0, 8'h00);
        do_wr(1'b0, 8'h04);
        checks++;
        if ({vif.vram_req, vif.vram_addr, overrun} !== {1'b1, 14'h2000, 1'b1})
        begin errors++; $display("FAIL new_addr_use got %b %h %b exp 1 2000 1",
            vif.vram_req, vif.vram_addr, overrun); end
        do_ack(0, 8'h00);
    endtask

    task automatic test_status();
        logic [7:0] d;
        rd_tick  = 1'b1;
        mode     = 1'b1;
        coll_set = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL coll_race_old got %h exp 00", dout); end
        step();
        rd_tick  = 1'b0;
        coll_set = 1'b0;
        do_rd(1'b1, d);
        checks++;
        if (d !== 8'h20) begin errors++; $display("FAIL coll_after got %h exp 20", d); end
        fifth_set = 1'b1;
        fifth_num = 5'd7;
        step();
        fifth_num = 5'd9;
        step();
        fifth_set = 1'b0;
        do_rd(1'b1, d);
        checks++;
        if (d !== 8'h47) begin errors++; $display("FAIL fifth_first got %h exp 47", d); end
        do_rd(1'b1, d);
        checks++;
        if (d !== 8'h07) begin errors++; $display("FAIL num_held got %h exp 07", d); end
    endtask

    task automatic test_reset_wait();
        do_wr(1'b0, 8'h77);
        checks++;
        if (vif.vram_req !== 1'b1) begin errors++; $display("FAIL rw_pre_req got %b exp 1", vif.vram_req); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({vif.vram_req, busy} !== 2'b00) begin errors++; $display("FAIL rw_async_drop got %b exp 00", {vif.vram_req, busy}); end
        step();
        reset = 1'b0;
        do_ack(0, 8'hEE);
        checks++;
        if ({vif.vram_req, busy, overrun, irq, vif.vram_we} !== 5'b00000)
        begin errors++; $display("FAIL rw_stray_ack got %b exp 00000",
            {vif.vram_req, busy, overrun, irq, vif.vram_we}); end
        checks++;
        if ({vif.vram_addr, vif.vram_wdata, regs} !== '0)
        begin errors++; $display("FAIL rw_outputs got %h %h %h exp 0 0 0",
            vif.vram_addr, vif.vram_wdata, regs); end
        mode = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL rw_dout_data got %h exp 00", dout); end
        mode = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL rw_dout_stat got %h exp 00", dout); end
    endtask

    initial begin
        vif.vram_ack   = 1'b0;
        vif.vram_rdata = 8'h00;
        test_reset();
        test_regs();
        test_write();
        test_read_wrap();
        test_overrun();
        test_status();
        test_reset_wait();
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdp99_cpu_port.md
Name: vdp99_cpu_port

Overview:
- CPU-facing register/VRAM access port of the vdp99 core, directly downstream of the Z80 bus bridge.
- Consumes the bridge's pxclk-domain wr_tick/rd_tick/mode/din strobes and produces dout for the bridge's read latch.
- Implements the TMS9918-style control protocol: two-byte control writes, 8 mode registers, an auto-incrementing VRAM address, a read-ahead buffer and the status register.
- Issues single-byte VRAM requests to the VRAM arbiter over a req/ack handshake.

Parameters:
- ADDR_W, 14, VRAM address counter width; the counter wraps modulo 2^ADDR_W.

Ports:
- pxclk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- wr_tick  in  1  one-cycle CPU write strobe.
- rd_tick  in  1  one-cycle CPU read strobe.
- mode  in  1  port select: 1 = control/status, 0 = data. Valid whenever a tick is high.
- din  in  8  CPU write data, valid with wr_tick.
- dout  out  8  combinational read data. mode=1 gives status; mode=0 gives rd_buf.
- irq  out  1  F & reg1[5].
- regs  out  64  mode registers, with reg n at bits [8n+7:8n].
- frame_tick  in  1  one-cycle pulse that sets status F.
- coll_set  in  1  sets status C.
- fifth_set  in  1  sets status 5S and loads fifth_num; ignored if 5S is already set.
- fifth_num  in  5  sprite number for status[4:0].
- vram_req  out  1  VRAM request.
- vram_we  out  1  1 = write, 0 = read.
- vram_addr  out  ADDR_W  request address.
- vram_wdata  out  8  write data.
- vram_ack  in  1  one-cycle completion pulse. vram_rdata is valid in the same cycle.
- vram_rdata  in  8  read data.
- busy  out  1  a VRAM request is outstanding.
- overrun  out  1  sticky flag: a VRAM-needing access arrived while busy.

Behaviour:
- Reset values: all registers, addr, rd_buf, status, latch byte, toggle, overrun and vram_req are 0. busy=0, irq=0, dout=0.
- Status byte: {F, 5S, C, num[4:0]}.
- Control write, first byte (toggle=0): latch <= din, toggle <= 1.
- Control write, second byte (toggle=1): toggle <= 0, then:
  - din[7]=1: regs[din[2:0]] <= latch. addr is untouched.
  - din[7]=0: addr <= {din[5:0], latch} (truncated or zero-extended to ADDR_W).
  - din[7:6]=00 additionally issues a VRAM read prefetch.
- Data write: toggle <= 0, rd_buf <= din, issue VRAM write of din.
- Data read: dout shows rd_buf during the rd_tick cycle. Then toggle <= 0 and a VRAM read prefetch is issued.
- Status read: dout shows the status in the rd_tick cycle. Next edge: F, 5S and C clear, num is held, toggle <= 0.
- Simultaneous status read and set event: the read returns the old value. Set wins, so the flag is 1 afterwards.
- Issue (state IDLE -> WAIT):
  - Edge after the tick: vram_req=1, vram_addr <= addr, vram_we as required, vram_wdata <= din.
  - Same edge: addr <= addr+1. 2^ADDR_W-1 wraps to 0.
- WAIT:
  - vram_req, vram_we, vram_addr and vram_wdata are held stable until vram_ack.
  - On the ack edge: state -> IDLE and vram_req=0 in the following cycle.
  - Read ack: rd_buf <= vram_rdata.
- busy = (state==WAIT).
- Busy conflicts:
  - A data read/write or read-setup arriving while busy is dropped and sets overrun.
  - A dropped access does not change addr, rd_buf or the VRAM outputs.
  - Its toggle and register side effects still apply.
  - A data read arriving while busy still returns the current rd_buf on dout.
- Address changes while busy: a control address write during WAIT changes addr only. The in-flight vram_addr is unaffected.
- vram_ack outside WAIT is ignored.
- wr_tick and rd_tick together cannot occur; if they do, wr_tick takes priority.
- Asynchronous reset mid-WAIT:
  - vram_req drops immediately.
  - The arbiter must discard the transaction.
  - A later stray ack is ignored.

Test Plan:
- Control write 0x55 then 0x81 -> regs[15:8]=0x55; addr unchanged; toggle=0. Set reg1[5] and pulse frame_tick -> irq=1; status read returns 0x80; irq=0 next cycle.
- Address setup for a write (0x34 then 0x52) -> addr=0x1234. Two data writes 0xAA, 0xBB with ack 3 cycles later each -> VRAM writes to 0x1234 and 0x1235; addr=0x1236; vram_req held until ack.
- Address setup for a read (0xFF then 0x3F), VRAM returns 0x5A -> request at 0x3FFF; addr wraps to 0x0000; rd_buf=0x5A. Next data read -> dout=0x5A, new read at 0x0000.
- Data write while busy -> overrun=1; no second request; addr advanced only once.
- Status read coincident with coll_set -> dout[5]=0; C=1 afterwards. fifth_set num=7 then num=9 -> status[4:0]=7.
- Reset asserted during WAIT -> vram_req=0 asynchronously. A later ack produces no state change; all outputs are 0.
